// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: AMBA 2 AHB round-robin arbiter with fixed-burst protection,
// early-termination handling and locked-transfer support.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTMASTLOCK,
    output logic                   burst_active
);
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic [NUM_MASTERS-1:0] gnt_q, gnt_d, gnt_win;
    logic [MW-1:0]          mst_q, mst_d, gidx, winner;
    logic                   lock_q, lock_d, err, arb_point, found;
    logic [4:0]             cnt_q, cnt_d, load;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (gnt_q[i]) gidx = MW'(i);
        load = HBURST[2:1] == 2'd0 ? 5'd0 : HBURST[2:1] == 2'd1 ? 5'd3 :
               HBURST[2:1] == 2'd2 ? 5'd7 : 5'd15;
        // First cycle of a two-cycle ERROR/RETRY/SPLIT response ends the burst early.
        err = HRESP != 2'b00 && !HREADY;
        cnt_d = err ? 5'd0 : !HREADY ? cnt_q :
                HTRANS == NONSEQ ? load :
                HTRANS == SEQ ? (cnt_q != 5'd0 ? cnt_q - 5'd1 : cnt_q) :
                HTRANS == IDLE ? 5'd0 : cnt_q;
        arb_point = (err || (HREADY && (HTRANS == IDLE || (HTRANS == NONSEQ && load == 5'd0) ||
                    (HTRANS == SEQ && cnt_q == 5'd1) || (HBURST == 3'b001 && HTRANS[1]))))
                    && !(HLOCKx[gidx] && HBUSREQx[gidx]);
        // Scan starts just after the current owner, so the owner itself is checked last.
        winner = MW'(DEFAULT_MASTER);
        found  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int idx;
            idx = (int'(mst_q) + k) % NUM_MASTERS;
            if (!found && HBUSREQx[idx]) begin
                winner = MW'(idx);
                found  = 1'b1;
            end
        end
        gnt_win = '0;
        gnt_win[winner] = 1'b1;
        gnt_d  = arb_point ? gnt_win : gnt_q;
        mst_d  = HREADY ? gidx : mst_q;
        lock_d = HREADY ? HLOCKx[gidx] : lock_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt_q  <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            mst_q  <= MW'(DEFAULT_MASTER);
            lock_q <= 1'b0;
            cnt_q  <= 5'd0;
        end else begin
            gnt_q  <= gnt_d;
            mst_q  <= mst_d;
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

    assign HGRANTx       = gnt_q;
    assign HMASTER       = mst_q;
    assign HMASTMASTLOCK = lock_q;
    assign burst_active  = cnt_q != 5'd0;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed vector table, randomized run against a
// behavioural model, and an asynchronous mid-burst reset check.
module tb_ahb_bus_arbiter;
    localparam int N = 4;
    localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SQ = 2'b11;

    logic         HCLK = 1'b0, HRESETn = 1'b1;
    logic [N-1:0] HBUSREQx = '0, HLOCKx = '0;
    logic [1:0]   HTRANS = IDLE, HRESP = 2'b00;
    logic [2:0]   HBURST = 3'b000;
    logic         HREADY = 1'b1;
    logic [N-1:0] HGRANTx;
    logic [1:0]   HMASTER;
    logic         HMASTMASTLOCK, burst_active;

    int tests = 0, fails = 0;
    int mg = 0, mm = 0, ml = 0, mc = 0;

    typedef struct packed {
        logic [3:0] req, lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [1:0] resp;
        logic [3:0] gnt;
        logic [1:0] mst;
        logic       ml, ba;
    } vec_t;
    vec_t tbl[$];

    ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
        .HGRANTx(HGRANTx), .HMASTER(HMASTER), .HMASTMASTLOCK(HMASTMASTLOCK),
        .burst_active(burst_active)
    );

    always #5 HCLK = ~HCLK;

    function automatic int beats(input logic [2:0] b);
        return b < 3'd2 ? 0 : b < 3'd4 ? 3 : b < 3'd6 ? 7 : 15;
    endfunction

    // Next state derived directly from the arbitration rules, using integers.
    task automatic model_edge();
        int ng, nc;
        bit err, ap;
        err = HRESP != 2'b00 && !HREADY;
        ap = err || (HREADY && (HTRANS == IDLE || (HTRANS == NS && beats(HBURST) == 0) ||
             (HTRANS == SQ && mc == 1) || (HBURST == 3'b001 && HTRANS >= NS)));
        if (HLOCKx[mg] && HBUSREQx[mg]) ap = 0;
        ng = mg;
        if (ap) begin
            ng = 0;
            for (int k = N; k >= 1; k--)
                if (HBUSREQx[(mm + k) % N]) ng = (mm + k) % N;
        end
        nc = mc;
        if (err) nc = 0;
        else if (HREADY) begin
            if (HTRANS == NS) nc = beats(HBURST);
            else if (HTRANS == SQ && mc > 0) nc = mc - 1;
            else if (HTRANS == IDLE) nc = 0;
        end
        if (HREADY) begin
            mm = mg;
            ml = HLOCKx[mg];
        end
        mg = ng;
        mc = nc;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got gnt/mst/lock/ba=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {HGRANTx, HMASTER, HMASTMASTLOCK, burst_active};
    endfunction

    function automatic logic [7:0] model_outs();
        logic [3:0] g;
        g = '0;
        g[mg] = 1'b1;
        return {g, 2'(mm), 1'(ml), mc != 0};
    endfunction

    task automatic step(input string name);
        @(posedge HCLK);
        model_edge();
        #1;
        check(name, outs(), model_outs());
    endtask

    task automatic drive(input logic [3:0] req, lock, input logic [1:0] tr, input logic [2:0] bu,
                         input logic rdy, input logic [1:0] rsp);
        HBUSREQx = req; HLOCKx = lock; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
    endtask

    task automatic add(input logic [3:0] req, lock, input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic [1:0] rsp, input logic [3:0] g,
                       input logic [1:0] m, input logic l, b);
        tbl.push_back({req, lock, tr, bu, rdy, rsp, g, m, l, b});
    endtask

    initial begin
        // round robin over an INCR4 burst
        add(4'b0000, 4'b0000, IDLE, 3'b000, 1, 2'b00, 4'b0001, 0, 0, 0);
        add(4'b0110, 4'b0000, IDLE, 3'b000, 1, 2'b00, 4'b0010, 0, 0, 0);
        add(4'b0110, 4'b0000, IDLE, 3'b000, 1, 2'b00, 4'b0010, 1, 0, 0);
        add(4'b0110, 4'b0000, NS,   3'b011, 1, 2'b00, 4'b0010, 1, 0, 1);
        add(4'b0110, 4'b0000, SQ,   3'b011, 1, 2'b00, 4'b0010, 1, 0, 1);
        add(4'b0110, 4'b0000, SQ,   3'b011, 1, 2'b00, 4'b0010, 1, 0, 1);
        add(4'b0110, 4'b0000, SQ,   3'b011, 1, 2'b00, 4'b0100, 1, 0, 0);
        add(4'b0110, 4'b0000, IDLE, 3'b011, 1, 2'b00, 4'b0100, 2, 0, 0);
        // stall on the final beat
        add(4'b0111, 4'b0000, NS,   3'b011, 1, 2'b00, 4'b0100, 2, 0, 1);
        add(4'b0111, 4'b0000, SQ,   3'b011, 1, 2'b00, 4'b0100, 2, 0, 1);
        add(4'b0111, 4'b0000, SQ,   3'b011, 1, 2'b00, 4'b0100, 2, 0, 1);
        add(4'b0111, 4'b0000, SQ,   3'b011, 0, 2'b00, 4'b0100, 2, 0, 1);
        add(4'b0111, 4'b0000, SQ,   3'b011, 0, 2'b00, 4'b0100, 2, 0, 1);
        add(4'b0111, 4'b0000, SQ,   3'b011, 0, 2'b00, 4'b0100, 2, 0, 1);
        add(4'b0111, 4'b0000, SQ,   3'b011, 1, 2'b00, 4'b0001, 2, 0, 0);
        add(4'b0111, 4'b0000, IDLE, 3'b000, 0, 2'b00, 4'b0001, 2, 0, 0);
        add(4'b0111, 4'b0000, IDLE, 3'b000, 1, 2'b00, 4'b0001, 0, 0, 0);
        // locked transfers by M3
        add(4'b1000, 4'b1000, IDLE, 3'b000, 1, 2'b00, 4'b1000, 0, 0, 0);
        add(4'b1111, 4'b1000, IDLE, 3'b000, 1, 2'b00, 4'b1000, 3, 1, 0);
        add(4'b1111, 4'b1000, NS,   3'b000, 1, 2'b00, 4'b1000, 3, 1, 0);
        add(4'b1111, 4'b1000, NS,   3'b000, 1, 2'b00, 4'b1000, 3, 1, 0);
        add(4'b0111, 4'b0000, IDLE, 3'b000, 1, 2'b00, 4'b0001, 3, 0, 0);
        // ERROR response inside WRAP8
        add(4'b0101, 4'b0000, IDLE, 3'b000, 1, 2'b00, 4'b0001, 0, 0, 0);
        add(4'b0101, 4'b0000, NS,   3'b100, 1, 2'b00, 4'b0001, 0, 0, 1);
        add(4'b0101, 4'b0000, SQ,   3'b100, 1, 2'b00, 4'b0001, 0, 0, 1);
        add(4'b0101, 4'b0000, SQ,   3'b100, 1, 2'b00, 4'b0001, 0, 0, 1);
        add(4'b0101, 4'b0000, SQ,   3'b100, 0, 2'b01, 4'b0100, 0, 0, 0);
        add(4'b0101, 4'b0000, IDLE, 3'b100, 1, 2'b01, 4'b0100, 2, 0, 0);

        #2 HRESETn = 1'b0;
        #1 check("reset_async", outs(), 8'b0001_00_0_0);
        @(posedge HCLK); #1 check("reset_held", outs(), 8'b0001_00_0_0);
        @(negedge HCLK) HRESETn = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].rdy, tbl[i].resp);
            step("model_vec");
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].gnt, tbl[i].mst, tbl[i].ml, tbl[i].ba});
        end

        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  2'($urandom), 3'($urandom), $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
            step("rand");
        end

        // INCR16 owned by M2, reset pulled low between edges with 9 beats left
        drive(4'b0100, 4'b0000, IDLE, 3'b111, 1, 2'b00);
        step("pre16_a");
        step("pre16_b");
        drive(4'b0100, 4'b0000, NS, 3'b111, 1, 2'b00);
        step("incr16_ns");
        HTRANS = SQ;
        for (int i = 0; i < 6; i++) step("incr16_seq");
        check("cnt9_active", {7'd0, burst_active}, {7'd0, mc == 9});
        #2 HRESETn = 1'b0;
        mg = 0; mm = 0; ml = 0; mc = 0;
        #1 check("reset_midburst", outs(), 8'b0001_00_0_0);
        @(negedge HCLK) HRESETn = 1'b1;
        drive(4'b0000, 4'b0000, IDLE, 3'b000, 1, 2'b00);
        step("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
